// File: rtl/multi_sprite_engine.sv
// multi_sprite_engine
//   Animates NUM_SPRITES sprites (horizontal bounce plus gravity jump) and
//   composites them over sky/grass/dirt bands with a one-cycle registered
//   pixel path. It also reports whether any two sprites overlapped during the
//   previous frame.
//
//   Ports
//     clk, rst_n   pixel clock, asynchronous active-low reset
//     hpos, vpos   current pixel from vga_sync
//     frame_end    one-cycle pulse on the last pixel of the frame
//     pause        freezes motion (collide still updates at frame_end)
//     jump         per-sprite jump request, sampled at frame_end
//     rgb_out      registered RrGgBb pixel (hpos/vpos of previous cycle)
//     in_sprite    registered per-sprite coverage, aligned with rgb_out
//     airborne     per-sprite Y state (1 = AIRBORNE)
//     collide      overlap seen anywhere in the previous frame

// Per-sprite lane: position/velocity state, Y FSM and pixel coverage test.
module multi_sprite_lane #(
    parameter int IDX       = 0,
    parameter int SPRITE_W  = 16,
    parameter int SPRITE_H  = 16,
    parameter int H_RES     = 640,
    parameter int GRASS_TOP = 384,
    parameter int JUMP_VEL  = 8,
    parameter int GRAVITY   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       jump,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       covers,
    output logic       airborne
);
    localparam logic signed [10:0] XR  = 11'(H_RES - SPRITE_W);
    localparam logic signed [10:0] YR  = 11'(GRASS_TOP - SPRITE_H);
    localparam logic signed [10:0] SPD = 11'(IDX + 1);
    localparam logic signed [7:0]  JV  = 8'(JUMP_VEL);
    localparam logic signed [7:0]  GR  = 8'(GRAVITY);
    localparam logic [9:0]         X0  = 10'(IDX * 2 * SPRITE_W);

    typedef enum logic {GROUNDED = 1'b0, AIRBORNE = 1'b1} ystate_t;

    ystate_t            st, st_nx;
    logic [9:0]         x, x_nx, y, y_nx;
    logic               dx, dx_nx;
    logic signed [7:0]  vy, vy_nx;
    logic signed [10:0] xs, tx, ty;

    assign xs = $signed({1'b0, x});
    // 11-bit signed intermediates keep x+s and y+vy from ever wrapping.
    assign tx = dx ? (xs + SPD) : (xs - SPD);
    assign ty = $signed({1'b0, y}) + $signed({{3{vy[7]}}, vy});

    always_comb begin
        x_nx  = x;
        dx_nx = dx;
        y_nx  = y;
        vy_nx = vy;
        st_nx = st;
        if (dx) begin
            if (tx >= XR) begin
                x_nx  = XR[9:0];
                dx_nx = 1'b0;
            end else begin
                x_nx = tx[9:0];
            end
        end else begin
            if (xs <= SPD) begin
                x_nx  = '0;
                dx_nx = 1'b1;
            end else begin
                x_nx = tx[9:0];
            end
        end
        unique case (st)
            GROUNDED: begin
                // Launch frame: y holds, velocity is loaded for next frame.
                if (jump) begin
                    vy_nx = JV;
                    st_nx = AIRBORNE;
                end
            end
            AIRBORNE: begin
                if (ty <= 11'sd0) begin
                    y_nx  = '0;
                    vy_nx = '0;
                    st_nx = GROUNDED;
                end else if (ty >= YR) begin
                    // Head bump: pin at the ceiling, then fall from rest.
                    y_nx  = YR[9:0];
                    vy_nx = '0;
                end else begin
                    y_nx  = ty[9:0];
                    vy_nx = vy - GR;
                end
            end
            default: st_nx = GROUNDED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= GROUNDED;
            x  <= X0;
            dx <= 1'b1;
            y  <= '0;
            vy <= '0;
        end else if (step) begin
            st <= st_nx;
            x  <= x_nx;
            dx <= dx_nx;
            y  <= y_nx;
            vy <= vy_nx;
        end
    end

    assign airborne = (st == AIRBORNE);

    // Coverage box: y is height above the grass, so the box top moves up as y grows.
    logic [10:0] h, v, left, top;
    assign h    = {1'b0, hpos};
    assign v    = {1'b0, vpos};
    assign left = {1'b0, x};
    assign top  = 11'(GRASS_TOP - SPRITE_H) - {1'b0, y};
    assign covers = (h >= left) && (h < left + 11'(SPRITE_W)) &&
                    (v >= top)  && (v < top + 11'(SPRITE_H));
endmodule

module multi_sprite_engine #(
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int H_RES       = 640,
    parameter int GRASS_TOP   = 384,
    parameter int DIRT_TOP    = 400,
    parameter int JUMP_VEL    = 8,
    parameter int GRAVITY     = 1,
    parameter logic [6*NUM_SPRITES-1:0] SPRITE_RGB = 12'b001100_100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic                   frame_end,
    input  logic                   pause,
    input  logic [NUM_SPRITES-1:0] jump,
    output logic [5:0]             rgb_out,
    output logic [NUM_SPRITES-1:0] in_sprite,
    output logic [NUM_SPRITES-1:0] airborne,
    output logic                   collide
);
    localparam logic [5:0] DIRT_RGB  = 6'b10_01_00;
    localparam logic [5:0] GRASS_RGB = 6'b01_10_00;
    localparam logic [5:0] SKY_RGB   = 6'b01_10_11;

    logic                   step;
    logic [NUM_SPRITES-1:0] cov;

    assign step = frame_end & ~pause;

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_lane
        multi_sprite_lane #(
            .IDX(gi), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .H_RES(H_RES),
            .GRASS_TOP(GRASS_TOP), .JUMP_VEL(JUMP_VEL), .GRAVITY(GRAVITY)
        ) u_lane (
            .clk(clk), .rst_n(rst_n), .step(step), .jump(jump[gi]),
            .hpos(hpos), .vpos(vpos), .covers(cov[gi]), .airborne(airborne[gi])
        );
    end

    // Compositor: scan high-to-low so the lowest-index sprite wins; terrain
    // bands override sprites.
    logic [5:0] pix;
    always_comb begin
        pix = SKY_RGB;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (cov[i]) pix = SPRITE_RGB[6*i +: 6];
        if (vpos >= 10'(DIRT_TOP))       pix = DIRT_RGB;
        else if (vpos >= 10'(GRASS_TOP)) pix = GRASS_RGB;
    end

    logic [2:0] ncov;
    always_comb begin
        ncov = '0;
        for (int i = 0; i < NUM_SPRITES; i++) ncov = ncov + 3'(cov[i]);
    end

    logic hit, acc;
    assign hit = (ncov >= 3'd2) && (hpos < 10'(H_RES)) && (vpos < 10'(GRASS_TOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            in_sprite <= '0;
            acc       <= 1'b0;
            collide   <= 1'b0;
        end else begin
            rgb_out   <= pix;
            in_sprite <= cov;
            if (frame_end) begin
                collide <= acc | hit;
                acc     <= 1'b0;
            end else begin
                acc <= acc | hit;
            end
        end
    end
endmodule

// File: tb/tb_multi_sprite_engine.sv
module tb_multi_sprite_engine;
    localparam int NS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    hpos = '0, vpos = '0;
    logic          frame_end = 1'b0, pause = 1'b0;
    logic [NS-1:0] jump = '0;
    logic [5:0]    rgb_out;
    logic [NS-1:0] in_sprite, airborne;
    logic          collide;

    multi_sprite_engine dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .frame_end(frame_end), .pause(pause), .jump(jump),
        .rgb_out(rgb_out), .in_sprite(in_sprite), .airborne(airborne),
        .collide(collide)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    rgb;
        logic [NS-1:0] ins;
        logic [NS-1:0] air;
        logic          col;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0, n_bad = 0;

    // Reference model state, in plain integers.
    int x[NS], y[NS], vy[NS], dir[NS];
    bit air[NS];
    bit acc, col;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            x[i] = i * 32; y[i] = 0; vy[i] = 0; dir[i] = 1; air[i] = 0;
        end
        acc = 0; col = 0;
    endtask

    function automatic bit on(int i, int h, int v);
        return h >= x[i] && h < x[i] + 16 && v >= 384 - y[i] - 16 && v < 384 - y[i];
    endfunction

    task automatic model_frame(input logic [NS-1:0] jmp);
        for (int i = 0; i < NS; i++) begin
            int s, t;
            s = i + 1;
            if (dir[i] == 1) begin
                if (x[i] + s >= 624) begin x[i] = 624; dir[i] = 0; end
                else x[i] = x[i] + s;
            end else begin
                if (x[i] <= s) begin x[i] = 0; dir[i] = 1; end
                else x[i] = x[i] - s;
            end
            if (!air[i]) begin
                if (jmp[i]) begin vy[i] = 8; air[i] = 1; end
            end else begin
                t = y[i] + vy[i];
                if (t <= 0)        begin y[i] = 0; vy[i] = 0; air[i] = 0; end
                else if (t >= 368) begin y[i] = 368; vy[i] = 0; end
                else               begin y[i] = t; vy[i] = vy[i] - 1; end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // One pixel cycle: drive at negedge, push the expected post-posedge outputs.
    task automatic drive(input int h, input int v, input bit fe, input bit pz,
                         input logic [NS-1:0] jmp);
        exp_t e;
        logic [NS-1:0] cv;
        int n;
        bit hit;
        @(negedge clk);
        hpos = 10'(h); vpos = 10'(v); frame_end = fe; pause = pz; jump = jmp;
        n = 0;
        for (int i = 0; i < NS; i++) begin
            cv[i] = on(i, h, v);
            n += int'(cv[i]);
        end
        if (v >= 400)      e.rgb = 6'b10_01_00;
        else if (v >= 384) e.rgb = 6'b01_10_00;
        else if (cv[0])    e.rgb = 6'b10_00_00;
        else if (cv[1])    e.rgb = 6'b00_11_00;
        else               e.rgb = 6'b01_10_11;
        e.ins = cv;
        hit = (n >= 2) && (h < 640) && (v < 384);
        if (fe) begin col = acc | hit; acc = 0; end
        else acc = acc | hit;
        if (fe && !pz) model_frame(jmp);
        for (int i = 0; i < NS; i++) e.air[i] = air[i];
        e.col = col;
        expq.push_back(e);
    endtask

    // Monitor: compare whatever the DUT registered at each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("rgb_out",   int'(rgb_out),   int'(e.rgb));
                check("in_sprite", int'(in_sprite), int'(e.ins));
                check("airborne",  int'(airborne),  int'(e.air));
                check("collide",   int'(collide),   int'(e.col));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_rgb"}, int'(rgb_out), 0);
        check({tag, "_ins"}, int'(in_sprite), 0);
        check({tag, "_air"}, int'(airborne), 0);
        check({tag, "_col"}, int'(collide), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        frame_end = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int clampi(int a, int lo, int hi);
        return (a < lo) ? lo : (a > hi) ? hi : a;
    endfunction

    initial begin
        bit pz;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Sprite 0 body just above the grass, then the two terrain bands.
        drive(3, 379, 0, 0, 2'b00);
        drive(3, 384, 0, 0, 2'b00);
        drive(3, 400, 0, 0, 2'b00);
        drive(35, 370, 0, 0, 2'b00);

        // Jump on sprite 0, request held for the whole arc (no retrigger).
        drive(0, 0, 1, 0, 2'b01);
        for (int k = 0; k < 20; k++) begin
            drive(x[0] + 4, 384 - y[0] - 8, 0, 0, 2'b01);
            drive(0, 0, 1, (k >= 5 && k < 15), 2'b01);
        end

        pz = 0;
        for (int c = 0; c < 24000; c++) begin
            int k, h, v;
            if ($urandom_range(0, 63) == 0) pz = ~pz;
            k = $urandom_range(0, 4);
            if (k < 2) begin
                h = x[k] + $urandom_range(0, 24) - 4;
                v = 384 - y[k] - 16 + $urandom_range(0, 24) - 4;
            end else if (k == 2) begin
                h = ((x[0] > x[1]) ? x[0] : x[1]) + $urandom_range(0, 3);
                v = 384 - y[0] - 16 + $urandom_range(0, 15);
            end else if (k == 3) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(376, 410);
            end else begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end
            drive(clampi(h, 0, 1023), clampi(v, 0, 1023),
                  ($urandom_range(0, 3) == 0), pz,
                  NS'({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)}));
            if (c == 12000) begin
                drive(0, 0, 1, 0, 2'b11);
                drive(0, 0, 1, 0, 2'b11);
                do_reset();
                pz = 0;
            end
        end
        repeat (3) @(negedge clk);
        if (expq.size() != 0) check("queue_drain", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_sprite_engine.md
Name: multi_sprite_engine

Overview:
- Parametrised successor to the single-sprite playfield renderer.
- Animates NUM_SPRITES sprites. Each sprite bounces horizontally at its own speed and can jump under gravity with a grounded/airborne state machine.
- Composites the sprites over sky/grass/dirt bands with a registered pixel path, and reports a per-frame sprite-overlap flag.
- Sits between vga_sync (timing) and the top-level RGB/PMOD packing.

Parameters:
NUM_SPRITES, 2, number of sprites (1..4)
SPRITE_W, 16, sprite width in pixels
SPRITE_H, 16, sprite height in pixels
H_RES, 640, visible width
GRASS_TOP, 384, first grass line; sprite bottom rests on it when y=0
DIRT_TOP, 400, first dirt line
JUMP_VEL, 8, initial upward velocity in px/frame (signed 8-bit, >0)
GRAVITY, 1, velocity decrement per frame
SPRITE_RGB, 12'b001100_100000, packed RrGgBb per sprite; sprite i uses bits [6i+5:6i]

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hpos  in  10  current pixel column from vga_sync
vpos  in  10  current pixel row from vga_sync
frame_end  in  1  one-cycle pulse on the last pixel of the frame (hmax & vmax)
pause  in  1  freezes all motion updates while high
jump  in  NUM_SPRITES  per-sprite jump request; level, sampled only at frame_end
rgb_out  out  6  RrGgBb pixel, registered
in_sprite  out  NUM_SPRITES  registered per-sprite coverage of the pixel, aligned with rgb_out
airborne  out  NUM_SPRITES  per-sprite state (1 = AIRBORNE)
collide  out  1  1 if any two sprites overlapped on any pixel during the previous frame

Behaviour:
- Ranges and widths:
  - X_RANGE = H_RES-SPRITE_W; Y_RANGE = GRASS_TOP-SPRITE_H.
  - x and y are 10-bit unsigned; vy is 8-bit signed.
  - Position arithmetic uses 11-bit signed intermediates; no wrap is permitted.
- Reset (async assert, sync deassert at the top level):
  - Sprite i: x = i*2*SPRITE_W, y = 0, vy = 0, dx = 1 (right), GROUNDED.
  - rgb_out = 0, in_sprite = 0, airborne = 0, collide = 0, collision accumulator = 0.
- Motion updates happen only on a cycle with frame_end=1 and pause=0. With pause=1, frame_end still updates collide; nothing else moves.
- X motion (speed s = i+1 px/frame):
  - dx=1 and x+s >= X_RANGE -> x = X_RANGE, dx = 0.
  - dx=0 and x <= s -> x = 0, dx = 1.
  - Otherwise x = x ± s.
- Y state machine per sprite:
  - GROUNDED: jump[i]=1 -> vy = JUMP_VEL, go AIRBORNE; y unchanged this frame. jump=0 -> stay.
  - AIRBORNE: t = y+vy.
    - t <= 0 -> y = 0, vy = 0, go GROUNDED.
    - t >= Y_RANGE -> y = Y_RANGE, vy = 0, stay AIRBORNE (head bump, then falls).
    - Otherwise y = t, vy = vy-GRAVITY.
  - jump is ignored while AIRBORNE.
  - airborne[i] is the state register directly.
- Sprite i covers (h,v) when x <= h < x+SPRITE_W and GRASS_TOP-y-SPRITE_H <= v < GRASS_TOP-y.
- Pixel path (latency 1 clk: rgb_out/in_sprite reflect the hpos/vpos of the previous cycle). Priority, highest first:
  1. dirt (v >= DIRT_TOP) = 10_01_00
  2. grass (v >= GRASS_TOP) = 01_10_00
  3. lowest-index covering sprite = SPRITE_RGB slice
  4. sky = 01_10_11
- Positions change only at frame_end, so the frame in progress never tears.
- Collision:
  - Accumulator ORs in (popcount(coverage) >= 2) on every cycle with hpos < H_RES and vpos < GRASS_TOP.
  - At frame_end: collide = accumulator (including the current pixel), then the accumulator clears.
- Blanking is applied downstream; this block does not gate rgb_out.

Test Plan:
- Reset: assert rst_n=0 mid-frame with sprite 1 airborne -> all outputs are 0 immediately; after release, x0=0, x1=32, y=0, airborne=00.
- X bounce: 624 frame_end pulses -> x0=624 with dx flipped; the next pulse gives x0=623. Sprite 1 reaches 624 after 296 pulses (32+2*296) and clamps there.
- Jump (JUMP_VEL=8, GRAVITY=1): jump[0]=1 for one frame_end -> the y sequence over the next 17 pulses is 8,15,21,26,30,33,35,36,36,35,33,30,26,21,15,8,0. airborne[0] clears on the 17th. A jump held throughout causes no re-trigger until grounded.
- Pause: pause=1 for 10 frame_end pulses during a jump -> x, y and vy are unchanged; resuming continues the exact sequence.
- Pixel path: hpos=x0+3, vpos=GRASS_TOP-5 -> rgb_out=10_00_00 and in_sprite[0]=1 one cycle later. vpos=GRASS_TOP -> 01_10_00; vpos=DIRT_TOP -> 10_01_00.
- Collision: force overlapping x (sprite 1 speed catches sprite 0 after the bounce) -> collide=1 after the frame_end ending the first overlapping frame; once they separate, collide returns to 0 one frame later.
